// File: rtl/id_stage_reg.sv
// id_stage_reg: ID/EXE pipeline register with flush, freeze, valid tracking and a bubble counter
module id_stage_reg (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        freeze,
   input  logic        WB_EN_in,
   input  logic        MEM_R_EN_in,
   input  logic        MEM_W_EN_in,
   input  logic        B_in,
   input  logic        S_in,
   input  logic [3:0]  EXE_CMD_in,
   input  logic [31:0] PC_in,
   input  logic [31:0] Val_Rn_in,
   input  logic [31:0] Val_Rm_in,
   input  logic        imm_in,
   input  logic [11:0] Shift_operand_in,
   input  logic [23:0] Signed_imm_24_in,
   input  logic [3:0]  Dest_in,
   input  logic [3:0]  src1_in,
   input  logic [3:0]  src2_in,
   input  logic        C_in,
   output logic        WB_EN,
   output logic        MEM_R_EN,
   output logic        MEM_W_EN,
   output logic        B,
   output logic        S,
   output logic [3:0]  EXE_CMD,
   output logic [31:0] PC,
   output logic [31:0] Val_Rn,
   output logic [31:0] Val_Rm,
   output logic        imm,
   output logic [11:0] Shift_operand,
   output logic [23:0] Signed_imm_24,
   output logic [3:0]  Dest,
   output logic [3:0]  src1,
   output logic [3:0]  src2,
   output logic        C,
   output logic        valid,
   output logic [7:0]  bubble_cnt
);
   logic       ctrl_any;
   logic [7:0] cnt_inc;
   // A slot is real when any control bit is set; the counter stops at 8'hFF
   always_comb begin
      ctrl_any = WB_EN_in | MEM_R_EN_in | MEM_W_EN_in | B_in | S_in | (|EXE_CMD_in);
      cnt_inc  = bubble_cnt + 8'(bubble_cnt != 8'hFF);
   end
   // Pipeline register: rst > flush > freeze > load; bubbles counted on flush or all-zero control load
   always_ff @(posedge clk or posedge rst)
      if (rst || flush) begin
         WB_EN         <= 1'b0;
         MEM_R_EN      <= 1'b0;
         MEM_W_EN      <= 1'b0;
         B             <= 1'b0;
         S             <= 1'b0;
         EXE_CMD       <= '0;
         PC            <= '0;
         Val_Rn        <= '0;
         Val_Rm        <= '0;
         imm           <= 1'b0;
         Shift_operand <= '0;
         Signed_imm_24 <= '0;
         Dest          <= '0;
         src1          <= '0;
         src2          <= '0;
         C             <= 1'b0;
         valid         <= 1'b0;
         bubble_cnt    <= rst ? 8'h00 : cnt_inc;
      end else if (!freeze) begin
         WB_EN         <= WB_EN_in;
         MEM_R_EN      <= MEM_R_EN_in;
         MEM_W_EN      <= MEM_W_EN_in;
         B             <= B_in;
         S             <= S_in;
         EXE_CMD       <= EXE_CMD_in;
         PC            <= PC_in;
         Val_Rn        <= Val_Rn_in;
         Val_Rm        <= Val_Rm_in;
         imm           <= imm_in;
         Shift_operand <= Shift_operand_in;
         Signed_imm_24 <= Signed_imm_24_in;
         Dest          <= Dest_in;
         src1          <= src1_in;
         src2          <= src2_in;
         C             <= C_in;
         valid         <= ctrl_any;
         bubble_cnt    <= ctrl_any ? bubble_cnt : cnt_inc;
      end
endmodule

// File: tb/tb_id_stage_reg.sv
// tb_id_stage_reg: scoreboard bench for the ID/EXE pipeline register
module tb_id_stage_reg;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, freeze = 1'b0;
   logic [154:0] din = '0;
   logic WB_EN, MEM_R_EN, MEM_W_EN, B, S, imm, C, valid;
   logic [3:0] EXE_CMD, Dest, src1, src2;
   logic [31:0] PC, Val_Rn, Val_Rm;
   logic [11:0] Shift_operand;
   logic [23:0] Signed_imm_24;
   logic [7:0] bubble_cnt;
   logic [163:0] obs;
   logic [154:0] m_data = '0;
   logic m_valid = 1'b0;
   logic [7:0] m_cnt = '0;
   logic [163:0] sb[$];
   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   id_stage_reg dut (
      .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
      .WB_EN_in(din[154]), .MEM_R_EN_in(din[153]), .MEM_W_EN_in(din[152]),
      .B_in(din[151]), .S_in(din[150]), .EXE_CMD_in(din[149:146]),
      .PC_in(din[145:114]), .Val_Rn_in(din[113:82]), .Val_Rm_in(din[81:50]),
      .imm_in(din[49]), .Shift_operand_in(din[48:37]), .Signed_imm_24_in(din[36:13]),
      .Dest_in(din[12:9]), .src1_in(din[8:5]), .src2_in(din[4:1]), .C_in(din[0]),
      .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .B(B), .S(S),
      .EXE_CMD(EXE_CMD), .PC(PC), .Val_Rn(Val_Rn), .Val_Rm(Val_Rm), .imm(imm),
      .Shift_operand(Shift_operand), .Signed_imm_24(Signed_imm_24),
      .Dest(Dest), .src1(src1), .src2(src2), .C(C), .valid(valid), .bubble_cnt(bubble_cnt)
   );

   assign obs = {WB_EN, MEM_R_EN, MEM_W_EN, B, S, EXE_CMD, PC, Val_Rn, Val_Rm, imm,
                 Shift_operand, Signed_imm_24, Dest, src1, src2, C, valid, bubble_cnt};

   task automatic check(input string tag, input logic [163:0] got, input logic [163:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step(input logic fl, input logic fz, input string tag);
      logic [163:0] e;
      flush = fl;
      freeze = fz;
      if (fl) begin
         m_data = '0;
         m_valid = 1'b0;
         m_cnt = (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
      end else if (!fz) begin
         m_data = din;
         m_valid = (|din[154:150]) || (din[149:146] != 4'd0);
         if (!m_valid) m_cnt = (m_cnt == 8'hFF) ? m_cnt : m_cnt + 8'd1;
      end
      sb.push_back({m_data, m_valid, m_cnt});
      @(posedge clk);
      #1;
      if (sb.size() == 0) check({tag, "_empty"}, 164'd1, 164'd0);
      else begin
         e = sb.pop_front();
         check(tag, obs, e);
      end
   endtask

   task automatic rand_din(input bit zero_ctrl);
      logic [159:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom};
      din = r[154:0];
      if (zero_ctrl) din[154:146] = '0;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      check({tag, "_async"}, obs, '0);
      @(posedge clk);
      #1;
      check({tag, "_held"}, obs, '0);
      @(negedge clk);
      rst = 1'b0;
      flush = 1'b0;
      freeze = 1'b0;
      m_data = '0;
      m_valid = 1'b0;
      m_cnt = '0;
   endtask

   initial begin
      #1;
      check("reset_init", obs, '0);
      @(negedge clk);
      rst = 1'b0;
      // basic load
      din = '0;
      din[154] = 1'b1;
      din[149:146] = 4'b0010;
      din[113:82] = 32'h12345678;
      din[12:9] = 4'd3;
      step(0, 0, "load");
      check("load_valrn", {132'd0, Val_Rn}, {132'd0, 32'h12345678});
      check("load_valid_cnt", {155'd0, valid, bubble_cnt}, {155'd0, 1'b1, 8'd0});
      // freeze holds for 3 edges, then new inputs load
      for (int i = 0; i < 3; i++) begin
         rand_din(i == 1);
         step(0, 1, "freeze");
      end
      rand_din(0);
      step(0, 0, "unfreeze");
      // flush beats freeze
      din = '0;
      din[153] = 1'b1;
      step(1, 1, "flush_freeze");
      check("flush_cnt", {156'd0, bubble_cnt}, {156'd0, 8'd1});
      // hazard bubble keeps data, counts
      din = '0;
      din[81:50] = 32'h0000DEAD;
      step(0, 0, "hazard");
      check("hazard_valrm", {132'd0, Val_Rm}, {132'd0, 32'h0000DEAD});
      check("hazard_cnt", {155'd0, valid, bubble_cnt}, {155'd0, 1'b0, 8'd2});
      // branch then flush of the following slot
      din = '0;
      din[151] = 1'b1;
      step(0, 0, "branch");
      rand_din(0);
      step(1, 0, "branch_flush");
      // mixed random traffic
      for (int i = 0; i < 60; i++) begin
         rand_din($urandom_range(0, 3) == 0);
         step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, "random");
      end
      // async reset with valid=1 and bubble_cnt=5, then normal load
      do_reset("rst_a");
      din = '0;
      for (int i = 0; i < 5; i++) step(0, 0, "bubble5");
      rand_din(0);
      din[154] = 1'b1;
      step(0, 0, "pre_rst");
      check("pre_rst_state", {155'd0, valid, bubble_cnt}, {155'd0, 1'b1, 8'd5});
      #3;
      do_reset("rst_mid");
      rand_din(0);
      din[152] = 1'b1;
      step(0, 0, "post_rst_load");
      // saturation over 300 flushes
      do_reset("rst_b");
      for (int i = 0; i < 300; i++) step(1, 0, "sat");
      check("sat_cnt", {156'd0, bubble_cnt}, {156'd0, 8'hFF});
      // reset overrides flush and freeze
      freeze = 1'b1;
      flush = 1'b1;
      #3;
      do_reset("rst_ff");
      rand_din(0);
      step(0, 0, "final_load");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
